// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sequences the 4-bank byte-write / word-read matrix memory and shares it
//   between a byte-streaming host (writes) and the NPU (word reads).
//   Generates the lo-byte / hi-byte / settle / commit cycle pattern required
//   by the memory's 16-bit word assembler, and owns mem_we/address/data.
//
// Ports
//   clk, rst          clock; synchronous active-low reset
//   host_start        pulse, open a write session (taken only in IDLE)
//   host_base         session start byte address (bit0 ignored)
//   host_len          number of 16-bit words in the session
//   host_valid/ready  byte handshake, host_data lo byte first then hi byte
//   wr_done           1-cycle pulse when the session completes
//   busy              high whenever the controller is not IDLE
//   rd_req/rd_addr    NPU read request (held until rd_ack), word index
//   rd_ack            combinational, high in the cycle the read is taken
//   rd_valid/rd_data  1-cycle pulse with {bank3,bank2,bank1,bank0}
//   mem_we, mem_address_in, mem_data_in   registered memory controls
//   mem_ram_out       {q3,q2,q1,q0} from the four banks
module mem_access_ctrl #(
    parameter int unsigned RD_LAT = 2,
    parameter int unsigned LEN_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             host_start,
    input  logic [15:0]      host_base,
    input  logic [LEN_W-1:0] host_len,
    input  logic             host_valid,
    input  logic [7:0]       host_data,
    output logic             host_ready,
    output logic             wr_done,
    output logic             busy,
    input  logic             rd_req,
    input  logic [12:0]      rd_addr,
    output logic             rd_ack,
    output logic             rd_valid,
    output logic [63:0]      rd_data,
    output logic             mem_we,
    output logic [15:0]      mem_address_in,
    output logic [7:0]       mem_data_in,
    input  logic [63:0]      mem_ram_out
);

    localparam int unsigned LAT_W = (RD_LAT < 2) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RD_LAT - 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_LO,
        WR_HI,
        WR_SETTLE,
        WR_COMMIT,
        RD_WAIT,
        RD_CAP
    } state_t;

    state_t           state, state_nxt;
    logic [15:0]      addr, addr_nxt;
    logic [LEN_W-1:0] wcnt, wcnt_nxt;
    logic [LAT_W-1:0] lat_cnt, lat_nxt;
    logic             ret_wr, ret_nxt;       // read interrupted a session: resume at WR_LO
    logic             rd_served, served_nxt; // a read was already taken since the last commit
    logic             we_nxt;
    logic [15:0]      maddr_nxt;
    logic [7:0]       mdata_nxt;
    logic             done_nxt;
    logic             rv_nxt;
    logic [63:0]      rdata_nxt;

    assign busy = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= IDLE;
            addr           <= '0;
            wcnt           <= '0;
            lat_cnt        <= '0;
            ret_wr         <= 1'b0;
            rd_served      <= 1'b0;
            mem_we         <= 1'b0;
            mem_address_in <= '0;
            mem_data_in    <= '0;
            wr_done        <= 1'b0;
            rd_valid       <= 1'b0;
            rd_data        <= '0;
        end else begin
            state          <= state_nxt;
            addr           <= addr_nxt;
            wcnt           <= wcnt_nxt;
            lat_cnt        <= lat_nxt;
            ret_wr         <= ret_nxt;
            rd_served      <= served_nxt;
            mem_we         <= we_nxt;
            mem_address_in <= maddr_nxt;
            mem_data_in    <= mdata_nxt;
            wr_done        <= done_nxt;
            rd_valid       <= rv_nxt;
            rd_data        <= rdata_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        addr_nxt   = addr;
        wcnt_nxt   = wcnt;
        lat_nxt    = lat_cnt;
        ret_nxt    = ret_wr;
        served_nxt = rd_served;
        we_nxt     = 1'b0;
        maddr_nxt  = mem_address_in;
        mdata_nxt  = mem_data_in;
        done_nxt   = 1'b0;
        rv_nxt     = 1'b0;
        rdata_nxt  = rd_data;
        host_ready = 1'b0;
        rd_ack     = 1'b0;

        case (state)
            IDLE: begin
                if (rd_req) begin
                    rd_ack    = 1'b1;
                    state_nxt = RD_WAIT;
                    lat_nxt   = LAT_INIT;
                    maddr_nxt = {2'b00, rd_addr, 1'b0};
                    ret_nxt   = 1'b0;
                    // A simultaneous start is latched now and opened after the
                    // read, with the first word guaranteed before the next read.
                    if (host_start) begin
                        if (host_len != '0) begin
                            addr_nxt   = host_base & 16'hFFFE;
                            wcnt_nxt   = host_len;
                            ret_nxt    = 1'b1;
                            served_nxt = 1'b1;
                        end else begin
                            done_nxt = 1'b1;
                        end
                    end
                end else if (host_start) begin
                    if (host_len != '0) begin
                        addr_nxt   = host_base & 16'hFFFE;
                        wcnt_nxt   = host_len;
                        served_nxt = 1'b0;
                        state_nxt  = WR_LO;
                    end else begin
                        done_nxt = 1'b1;
                    end
                end
            end

            WR_LO: begin
                if (rd_req && !rd_served) begin
                    rd_ack     = 1'b1;
                    state_nxt  = RD_WAIT;
                    lat_nxt    = LAT_INIT;
                    maddr_nxt  = {2'b00, rd_addr, 1'b0};
                    ret_nxt    = 1'b1;
                    served_nxt = 1'b1;
                end else begin
                    host_ready = 1'b1;
                    if (host_valid) begin
                        maddr_nxt = addr;
                        mdata_nxt = host_data;
                        state_nxt = WR_HI;
                    end
                end
            end

            WR_HI: begin
                host_ready = 1'b1;
                if (host_valid) begin
                    maddr_nxt = addr | 16'h0001;
                    mdata_nxt = host_data;
                    state_nxt = WR_SETTLE;
                end
            end

            WR_SETTLE: begin
                we_nxt    = 1'b1;
                state_nxt = WR_COMMIT;
            end

            WR_COMMIT: begin
                addr_nxt   = addr + 16'd2;
                wcnt_nxt   = wcnt - LEN_W'(1);
                served_nxt = 1'b0;
                if (wcnt == LEN_W'(1)) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    state_nxt = WR_LO;
                end
            end

            RD_WAIT: begin
                if (lat_cnt == '0) begin
                    state_nxt = RD_CAP;
                end else begin
                    lat_nxt = lat_cnt - LAT_W'(1);
                end
            end

            RD_CAP: begin
                rdata_nxt = mem_ram_out;
                rv_nxt    = 1'b1;
                state_nxt = ret_wr ? WR_LO : IDLE;
            end

            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed testbench for mem_access_ctrl with a behavioural 4-bank memory
// (byte assembler + two-stage read pipeline) attached to the mem_* ports.
module tb_mem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        host_start;
    logic [15:0] host_base;
    logic [15:0] host_len;
    logic        host_valid;
    logic [7:0]  host_data;
    logic        host_ready;
    logic        wr_done;
    logic        busy;
    logic        rd_req;
    logic [12:0] rd_addr;
    logic        rd_ack;
    logic        rd_valid;
    logic [63:0] rd_data;
    logic        mem_we;
    logic [15:0] mem_address_in;
    logic [7:0]  mem_data_in;
    logic [63:0] mem_ram_out;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_access_ctrl #(.RD_LAT(2), .LEN_W(16)) dut (
        .clk(clk), .rst(rst),
        .host_start(host_start), .host_base(host_base), .host_len(host_len),
        .host_valid(host_valid), .host_data(host_data), .host_ready(host_ready),
        .wr_done(wr_done), .busy(busy),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .mem_we(mem_we), .mem_address_in(mem_address_in),
        .mem_data_in(mem_data_in), .mem_ram_out(mem_ram_out)
    );

    // Memory model: initial word at bank b, index i is {b,1'b0,i}.
    logic        mem_clear;
    logic [15:0] bank_mem [4][8192];
    logic [7:0]  lo_b, hi_b;
    logic [63:0] pipe1, ram_q;
    logic [12:0] idx;
    assign idx = mem_address_in[13:1];
    assign mem_ram_out = ram_q;

    always @(posedge clk) begin
        if (mem_clear) begin
            for (int b = 0; b < 4; b++)
                for (int i = 0; i < 8192; i++)
                    bank_mem[b][i] <= {b[1:0], 1'b0, i[12:0]};
            lo_b  <= '0;
            hi_b  <= '0;
            pipe1 <= '0;
            ram_q <= '0;
        end else begin
            if (mem_we)
                bank_mem[mem_address_in[15:14]][idx] <= {hi_b, lo_b};
            else if (mem_address_in[0])
                hi_b <= mem_data_in;
            else
                lo_b <= mem_data_in;
            pipe1 <= {bank_mem[3][idx], bank_mem[2][idx], bank_mem[1][idx], bank_mem[0][idx]};
            ram_q <= pipe1;
        end
    end

    // Event monitor
    int          we_cnt   = 0;
    int          done_cnt = 0;
    logic [15:0] commit_q[$];
    logic [7:0]  ev_q[$];
    always @(negedge clk) begin
        if (rd_ack) ev_q.push_back(8'h52);
        if (mem_we) begin
            we_cnt++;
            commit_q.push_back(mem_address_in);
            ev_q.push_back(8'h57);
        end
        if (wr_done) done_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session(input logic [15:0] base, input logic [15:0] len);
        host_base  = base;
        host_len   = len;
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        ok = 1'b0;
        host_valid = 1'b1;
        host_data  = b;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (host_ready) begin
                tick();
                ok = 1'b1;
                break;
            end
        end
        host_valid = 1'b0;
    endtask

    task automatic do_read(input logic [12:0] a, output logic [63:0] d, output bit ok);
        bit got;
        got = 1'b0;
        ok  = 1'b0;
        d   = '0;
        rd_addr = a;
        rd_req  = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (rd_ack) begin
                got = 1'b1;
                break;
            end
        end
        tick();
        rd_req = 1'b0;
        if (got) begin
            for (int i = 0; i < 20; i++) begin
                @(negedge clk);
                if (rd_valid) begin
                    d  = rd_data;
                    ok = 1'b1;
                    break;
                end
            end
        end
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (wr_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_cmp++;
        if ({busy, mem_we, host_ready, wr_done, rd_valid, rd_ack} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 000000",
                     {busy, mem_we, host_ready, wr_done, rd_valid, rd_ack});
        end
        n_cmp++;
        if ({mem_address_in, mem_data_in} !== 24'h0) begin
            n_fail++;
            $display("FAIL reset_mem_bus: got %h want 000000", {mem_address_in, mem_data_in});
        end
        n_cmp++;
        if (rd_data !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_rd_data: got %h want 0", rd_data);
        end
    endtask

    task automatic test_read_latency();
        logic [5:1]  vb;
        logic [63:0] d4, d5;
        vb = '0;
        d4 = '0;
        d5 = '0;
        tick();
        rd_addr = 13'd5;
        rd_req  = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rd_ack !== 1'b1) begin
            n_fail++;
            $display("FAIL lat_ack: got %b want 1", rd_ack);
        end
        tick();
        rd_req = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            vb[k] = rd_valid;
            if (k == 1) begin
                n_cmp++;
                if (mem_address_in !== 16'h000A || mem_we !== 1'b0) begin
                    n_fail++;
                    $display("FAIL lat_addr: got %h we %b want 000a we 0", mem_address_in, mem_we);
                end
            end
            if (k == 4) d4 = rd_data;
            if (k == 5) d5 = rd_data;
        end
        n_cmp++;
        if (vb !== 5'b01000) begin
            n_fail++;
            $display("FAIL lat_valid_timing: got %b want 01000 (cycles t+5..t+1)", vb);
        end
        n_cmp++;
        if (d4 !== 64'hC005_8005_4005_0005) begin
            n_fail++;
            $display("FAIL lat_data: got %h want c005800540050005", d4);
        end
        n_cmp++;
        if (d5 !== 64'hC005_8005_4005_0005) begin
            n_fail++;
            $display("FAIL lat_data_hold: got %h want c005800540050005", d5);
        end
    endtask

    task automatic test_write();
        int c0, d0;
        bit ok1, ok2, okd, okr;
        logic [63:0] d;
        c0 = commit_q.size();
        d0 = done_cnt;
        start_session(16'h0000, 16'd1);
        send_byte(8'h34, ok1);
        send_byte(8'h12, ok2);
        wait_done(okd);
        tick();
        n_cmp++;
        if (!(ok1 && ok2 && okd)) begin
            n_fail++;
            $display("FAIL wr_handshake: got acc %b%b done %b want 111", ok1, ok2, okd);
        end
        n_cmp++;
        if (commit_q.size() - c0 != 1 || commit_q[c0] !== 16'h0001) begin
            n_fail++;
            $display("FAIL wr_commit: got %0d commits first %h want 1 at 0001",
                     commit_q.size() - c0, (commit_q.size() > c0) ? commit_q[c0] : 16'hxxxx);
        end
        n_cmp++;
        if (done_cnt - d0 != 1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_done_cnt: got %0d busy %b want 1 busy 0", done_cnt - d0, busy);
        end
        do_read(13'd0, d, okr);
        n_cmp++;
        if (!okr || d !== 64'hC000_8000_4000_1234) begin
            n_fail++;
            $display("FAIL wr_readback: got %h ok %b want c000800040001234", d, okr);
        end
    endtask

    task automatic test_bank_cross();
        int c0, d0;
        bit ok, okall, okd, okr;
        logic [63:0] d;
        logic [7:0]  bytes [4];
        bytes = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        c0 = commit_q.size();
        d0 = done_cnt;
        okall = 1'b1;
        start_session(16'h3FFE, 16'd2);
        for (int i = 0; i < 4; i++) begin
            send_byte(bytes[i], ok);
            okall &= ok;
        end
        wait_done(okd);
        tick();
        n_cmp++;
        if (!(okall && okd) || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL cross_done: got acc %b done %b cnt %0d want 1 1 1", okall, okd, done_cnt - d0);
        end
        n_cmp++;
        if (commit_q.size() - c0 != 2 || commit_q[c0] !== 16'h3FFF || commit_q[c0+1] !== 16'h4001) begin
            n_fail++;
            $display("FAIL cross_commits: got %0d commits want 2 at 3fff,4001", commit_q.size() - c0);
        end
        do_read(13'h1FFF, d, okr);
        n_cmp++;
        if (!okr || d !== 64'hDFFF_9FFF_5FFF_BBAA) begin
            n_fail++;
            $display("FAIL cross_read_1fff: got %h want dfff9fff5fffbbaa", d);
        end
        do_read(13'h0000, d, okr);
        n_cmp++;
        if (!okr || d !== 64'hC000_8000_DDCC_1234) begin
            n_fail++;
            $display("FAIL cross_read_0: got %h want c0008000ddcc1234", d);
        end
    endtask

    task automatic test_wrap();
        int c0, d0, w0, w_at_done;
        bit ok, okall, okd, okr;
        logic [63:0] d;
        logic [7:0]  bytes [4];
        bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        c0 = commit_q.size();
        d0 = done_cnt;
        w0 = we_cnt;
        okall = 1'b1;
        start_session(16'hFFFE, 16'd2);
        for (int i = 0; i < 4; i++) begin
            send_byte(bytes[i], ok);
            okall &= ok;
        end
        wait_done(okd);
        w_at_done = we_cnt - w0;
        repeat (4) tick();
        n_cmp++;
        if (!(okall && okd) || w_at_done != 2) begin
            n_fail++;
            $display("FAIL wrap_done_order: got acc %b done %b commits_before %0d want 1 1 2",
                     okall, okd, w_at_done);
        end
        n_cmp++;
        if (done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL wrap_done_once: got %0d want 1", done_cnt - d0);
        end
        n_cmp++;
        if (commit_q.size() - c0 != 2 || commit_q[c0] !== 16'hFFFF || commit_q[c0+1] !== 16'h0001) begin
            n_fail++;
            $display("FAIL wrap_commits: got %0d commits want 2 at ffff,0001", commit_q.size() - c0);
        end
        do_read(13'h0000, d, okr);
        n_cmp++;
        if (!okr || d !== 64'hC000_8000_DDCC_4433) begin
            n_fail++;
            $display("FAIL wrap_read_0: got %h want c0008000ddcc4433", d);
        end
        do_read(13'h1FFF, d, okr);
        n_cmp++;
        if (!okr || d !== 64'h2211_9FFF_5FFF_BBAA) begin
            n_fail++;
            $display("FAIL wrap_read_1fff: got %h want 22119fff5fffbbaa", d);
        end
    endtask

    task automatic test_reset_mid();
        int w0;
        bit ok1, ok2;
        start_session(16'h0200, 16'd1);
        send_byte(8'h55, ok1);
        send_byte(8'h66, ok2);
        // now in the settle cycle; the commit must never appear
        w0 = we_cnt;
        rst = 1'b0;
        tick();
        @(negedge clk);
        n_cmp++;
        if ({busy, mem_we, host_ready, wr_done, rd_valid} !== 5'b0) begin
            n_fail++;
            $display("FAIL rstmid_flags: got %b want 00000", {busy, mem_we, host_ready, wr_done, rd_valid});
        end
        n_cmp++;
        if ({mem_address_in, mem_data_in} !== 24'h0 || rd_data !== 64'h0) begin
            n_fail++;
            $display("FAIL rstmid_regs: got bus %h rd_data %h want 0 0",
                     {mem_address_in, mem_data_in}, rd_data);
        end
        tick();
        rst = 1'b1;
        repeat (5) tick();
        n_cmp++;
        if (we_cnt != w0 || busy !== 1'b0 || !(ok1 && ok2)) begin
            n_fail++;
            $display("FAIL rstmid_no_we: got %0d we pulses busy %b acc %b%b want 0 0 11",
                     we_cnt - w0, busy, ok1, ok2);
        end
    endtask

    task automatic test_fairness();
        int c0, d0, e0;
        bit okall, seen3;
        logic [63:0] d;
        bit okr;
        logic [7:0] exp_ev [6];
        exp_ev = '{8'h52, 8'h57, 8'h52, 8'h57, 8'h52, 8'h57};
        c0 = commit_q.size();
        d0 = done_cnt;
        e0 = ev_q.size();
        okall = 1'b1;
        seen3 = 1'b0;
        host_base  = 16'h0100;
        host_len   = 16'd3;
        rd_addr    = 13'h0080;
        rd_req     = 1'b1;
        host_start = 1'b1;
        tick();
        host_start = 1'b0;
        fork
            begin
                bit ok;
                for (int i = 0; i < 6; i++) begin
                    send_byte(8'(i + 1), ok);
                    okall &= ok;
                end
            end
            begin
                int n;
                n = 0;
                for (int i = 0; i < 300; i++) begin
                    @(negedge clk);
                    if (mem_we) n++;
                    if (n == 3) begin
                        seen3 = 1'b1;
                        break;
                    end
                end
                tick();
                rd_req = 1'b0;
            end
        join
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        tick();
        n_cmp++;
        if (!(okall && seen3) || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL fair_done: got acc %b commits3 %b done %0d want 1 1 1", okall, seen3, done_cnt - d0);
        end
        n_cmp++;
        if (commit_q.size() - c0 != 3 || commit_q[c0] !== 16'h0101 ||
            commit_q[c0+1] !== 16'h0103 || commit_q[c0+2] !== 16'h0105) begin
            n_fail++;
            $display("FAIL fair_commits: got %0d commits want 3 at 0101,0103,0105", commit_q.size() - c0);
        end
        n_cmp++;
        if (ev_q.size() - e0 != 6) begin
            n_fail++;
            $display("FAIL fair_event_count: got %0d want 6", ev_q.size() - e0);
        end else begin
            for (int i = 0; i < 6; i++) begin
                n_cmp++;
                if (ev_q[e0+i] !== exp_ev[i]) begin
                    n_fail++;
                    $display("FAIL fair_order[%0d]: got %c want %c", i, ev_q[e0+i], exp_ev[i]);
                end
            end
        end
        do_read(13'h0082, d, okr);
        n_cmp++;
        if (!okr || d !== 64'hC082_8082_4082_0605) begin
            n_fail++;
            $display("FAIL fair_readback: got %h want c082808240820605", d);
        end
    endtask

    task automatic test_len0();
        int d0, w0;
        d0 = done_cnt;
        w0 = we_cnt;
        tick();
        host_base  = 16'h1234;
        host_len   = 16'd0;
        host_start = 1'b1;
        host_valid = 1'b1;
        host_data  = 8'h99;
        @(negedge clk);
        tick();
        host_start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (wr_done !== 1'b1 || busy !== 1'b0 || host_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL len0_pulse: got done %b busy %b ready %b want 1 0 0", wr_done, busy, host_ready);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (wr_done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL len0_after: got done %b busy %b want 0 0", wr_done, busy);
        end
        host_valid = 1'b0;
        tick();
        n_cmp++;
        if (done_cnt - d0 != 1 || we_cnt != w0) begin
            n_fail++;
            $display("FAIL len0_counts: got done %0d we %0d want 1 0", done_cnt - d0, we_cnt - w0);
        end
    endtask

    initial begin
        rst        = 1'b0;
        mem_clear  = 1'b1;
        host_start = 1'b0;
        host_base  = '0;
        host_len   = '0;
        host_valid = 1'b0;
        host_data  = '0;
        rd_req     = 1'b0;
        rd_addr    = '0;
        repeat (3) @(posedge clk);
        #1;
        mem_clear = 1'b0;
        test_reset();
        rst = 1'b1;
        tick();
        test_read_latency();
        test_write();
        test_bank_cross();
        test_wrap();
        test_reset_mid();
        test_fairness();
        test_len0();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
